revaluate_multi_gen: RTL and testbench
======================================

Name: revaluate_multi_gen

Overview:
Parametrised successor of the single-pass revaluate engine. It loads a NUM_CELLS-wide 1-D cell vector and applies an 8-bit Wolfram-style rule for a programmable number of generations, one generation per clock. Control is a start/busy/done handshake. It sits beside the existing revaluate top and is driven by the same system controller.

Parameters:
NUM_CELLS, 16, number of cells in the vector (>= 3).
GEN_W, 8, width of the generation-count input and counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new run; sampled only in IDLE.
data_in  input  NUM_CELLS  initial cell vector; captured on the accepted start.
rule  input  8  update rule; captured on the accepted start.
generations  input  GEN_W  number of generations to apply; captured on the accepted start.
busy  output  1  high while in EVAL.
done  output  1  one-cycle pulse when the result is valid.
data_out  output  NUM_CELLS  current cell register; final result once done pulses.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state goes to IDLE. Cell register, counter, busy, done and data_out are all 0. Captured rule is 0.
- Rule evaluation:
  - For cell i, form idx = {L, C, R}, where C = cell[i], L = cell[i+1] and R = cell[i-1]. The MSB is the leftmost cell.
  - The next value is rule[idx].
  - Out-of-range neighbours are 0, unless REVAL_WRAP_EN is defined.
  - All cells update simultaneously from the previous generation.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - On start=1 at an edge, latch data_in, rule and generations.
  - Go to EVAL if generations != 0, else go to DONE.
  - start=0 keeps the FSM in IDLE.
- EVAL:
  - Each edge applies one generation and decrements the counter.
  - When the counter equals 1 at the edge, that generation is applied and the FSM goes to DONE.
  - busy is 1 throughout EVAL.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
- Latency: counting the start-accepting edge as edge 0, done is visible after edge N, where N = generations. This holds for N=0 too (done after edge 0).
- data_out holds its value after DONE until the next accepted start.
- start while in EVAL or DONE is ignored. Input changes after the start edge have no effect.
- rst asserted mid-run wins over all else and aborts the run. No done pulse is produced.
- Counter width is GEN_W. The maximum run is 2^GEN_W - 1 generations, with no wrap.

Optional Feature:
Macro REVAL_WRAP_EN.
- Defined: toroidal boundary. Cell NUM_CELLS-1's left neighbour is cell 0, and cell 0's right neighbour is cell NUM_CELLS-1.
- Undefined: zero boundary; both edge neighbours read 0.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/EVAL/DONE localparams).
  - Named rule constants: RULE_CLEAR=8'h00, RULE_IDENT=8'hCC, RULE_SHIFT_L=8'hAA, RULE_90=8'h5A.
- One sub-module: reval_next_gen.
  - Combinational function from (cells, rule) to next cells.
  - Contains the per-cell 8:1 mux and the boundary handling under REVAL_WRAP_EN.
- FSM, counter and registers stay in the top.

Test Plan:
- NUM_CELLS=8, rule=0x5A, data_in=8'b00010000, generations=1 -> done after edge 1, data_out=8'b00101000, busy high for 1 cycle.
- rule=0xCC, data_in=8'hA5, generations=5 -> data_out=8'hA5 after edge 5. done is one cycle wide; busy is high 5 cycles.
- generations=0, data_in=8'h3C, any rule -> busy never rises. done after edge 0, data_out=8'h3C.
- rule=0xAA, data_in=8'b10000000, generations=1 -> data_out=8'h00 without the macro, 8'h01 with REVAL_WRAP_EN. With generations=3 and REVAL_WRAP_EN -> 8'h04.
- Start a run with generations=10. Pulse start with different data_in at cycle 3 -> it is ignored; the result matches the first run and done pulses once.
- Start a run with generations=10. Assert rst at cycle 4 -> next cycle state is IDLE, data_out=0, busy=0, no done. A following start with generations=1 completes normally.

Source files
------------

// File: rtl/revaluate_multi_gen_pkg.sv
// rtl/revaluate_multi_gen_pkg.sv - shared FSM encoding and named rules for revaluate_multi_gen
// The optional REVAL_WRAP_EN build changes only the boundary handling in reval_next_gen.
package revaluate_multi_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] RULE_CLEAR   = 8'h00;
   localparam logic [7:0] RULE_IDENT   = 8'hCC;
   localparam logic [7:0] RULE_SHIFT_L = 8'hAA;
   localparam logic [7:0] RULE_90      = 8'h5A;

endpackage

// File: rtl/revaluate_multi_gen_if.sv
// rtl/revaluate_multi_gen_if.sv - start/busy/done run interface of revaluate_multi_gen
// Master is the system controller, slave is the engine.
interface revaluate_multi_gen_if #(
   parameter int NUM_CELLS = 16,
   parameter int GEN_W     = 8
);
   logic                 start;
   logic [NUM_CELLS-1:0] data_in;
   logic [7:0]           rule;
   logic [GEN_W-1:0]     generations;
   logic                 busy;
   logic                 done;
   logic [NUM_CELLS-1:0] data_out;

   modport master (
      output start, data_in, rule, generations,
      input  busy, done, data_out
   );

   modport slave (
      input  start, data_in, rule, generations,
      output busy, done, data_out
   );
endinterface

// File: rtl/revaluate_multi_gen_next_gen.sv
// rtl/revaluate_multi_gen_next_gen.sv - one combinational generation of the cell vector
// Boundary neighbours read 0 unless REVAL_WRAP_EN selects a toroidal ring.
module reval_next_gen #(
   parameter int NUM_CELLS = 16
) (
   input  logic [NUM_CELLS-1:0] cells,
   input  logic [7:0]           rule,
   output logic [NUM_CELLS-1:0] next_cells
);

   logic edge_l;
   logic edge_r;

`ifdef REVAL_WRAP_EN
   assign edge_l = cells[0];
   assign edge_r = cells[NUM_CELLS-1];
`else
   assign edge_l = 1'b0;
   assign edge_r = 1'b0;
`endif

   // Left neighbour sits at the higher index, right neighbour at the lower index.
   for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
      logic l;
      logic r;
      if (i == NUM_CELLS - 1) begin : g_left_edge
         assign l = edge_l;
      end else begin : g_left_inner
         assign l = cells[i+1];
      end
      if (i == 0) begin : g_right_edge
         assign r = edge_r;
      end else begin : g_right_inner
         assign r = cells[i-1];
      end
      assign next_cells[i] = rule[{l, cells[i], r}];
   end

endmodule

// File: rtl/revaluate_multi_gen.sv
// rtl/revaluate_multi_gen.sv - multi-generation 1-D cellular automaton engine
// Build option REVAL_WRAP_EN selects toroidal boundaries (see reval_next_gen).
module revaluate_multi_gen
   import revaluate_multi_gen_pkg::*;
#(
   parameter int NUM_CELLS = 16,
   parameter int GEN_W     = 8
) (
   input logic                   clk,
   input logic                   rst,
   revaluate_multi_gen_if.slave  bus
);

   state_t               state_q;
   state_t               state_d;
   logic [NUM_CELLS-1:0] cells_q;
   logic [NUM_CELLS-1:0] next_cells;
   logic [7:0]           rule_q;
   logic [GEN_W-1:0]     cnt_q;
   logic                 busy;
   logic                 done;

   reval_next_gen #(.NUM_CELLS(NUM_CELLS)) u_next_gen (
      .cells      (cells_q),
      .rule       (rule_q),
      .next_cells (next_cells)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cells_q <= '0;
         rule_q  <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  cells_q <= bus.data_in;
                  rule_q  <= bus.rule;
                  cnt_q   <= bus.generations;
               end
            end
            ST_EVAL: begin
               cells_q <= next_cells;
               cnt_q   <= cnt_q - GEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // A zero-generation run skips EVAL so done still lands right after the start edge.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = (bus.generations != '0) ? ST_EVAL : ST_DONE;
            end
         end
         ST_EVAL: begin
            busy = 1'b1;
            if (cnt_q == GEN_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.data_out = cells_q;

endmodule

// File: tb/tb_revaluate_multi_gen.sv
// tb/tb_revaluate_multi_gen.sv - self-checking bench for revaluate_multi_gen (REVAL_WRAP_EN aware)
// Elapsed-time reference model plus directed literal runs and randomized traffic.
module tb_revaluate_multi_gen;
   import revaluate_multi_gen_pkg::*;

   localparam int NC = 8;
   localparam int GW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   npass = 0;
   int   ntotal = 0;
   bit   cmp_en = 1'b0;

   revaluate_multi_gen_if #(.NUM_CELLS(NC), .GEN_W(GW)) bus ();

   revaluate_multi_gen #(.NUM_CELLS(NC), .GEN_W(GW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [NC-1:0] ref_step(input logic [NC-1:0] c, input logic [7:0] r);
      logic [NC-1:0] n;
      for (int i = 0; i < NC; i++) begin
         int lv, rv, idx;
`ifdef REVAL_WRAP_EN
         lv = int'(c[(i + 1) % NC]);
         rv = int'(c[(i + NC - 1) % NC]);
`else
         lv = (i + 1 < NC) ? int'(c[i + 1]) : 0;
         rv = (i > 0) ? int'(c[i - 1]) : 0;
`endif
         idx = lv * 4 + int'(c[i]) * 2 + rv;
         n[i] = r[idx];
      end
      return n;
   endfunction

   // Model: s counts edges since the accepted start, n is the requested run length.
   bit            m_active = 1'b0;
   int            m_s = 0;
   int            m_n = 0;
   logic [NC-1:0] m_cells = '0;
   logic [7:0]    m_rule = '0;
   logic          exp_busy = 1'b0;
   logic          exp_done = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_active = 1'b0;
         m_cells  = '0;
      end else if (!m_active || m_s > m_n) begin
         if (bus.start) begin
            m_active = 1'b1;
            m_s      = 0;
            m_n      = int'(bus.generations);
            m_cells  = bus.data_in;
            m_rule   = bus.rule;
         end
      end else begin
         m_s++;
         if (m_s <= m_n) m_cells = ref_step(m_cells, m_rule);
      end
      exp_busy = m_active && (m_s < m_n);
      exp_done = m_active && (m_s == m_n);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model_busy", bus.busy, exp_busy);
         check("model_done", bus.done, exp_done);
         check("model_data", bus.data_out, m_cells);
      end
   end

   task automatic run_directed(input logic [7:0] d, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] exp, input string name);
      int  k = 0;
      int  bcnt = 0;
      bit  seen = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.data_in = d;
      bus.rule = r;
      bus.generations = g;
      @(negedge clk);
      bus.start = 1'b0;
      for (int t = 0; t < 300 && !seen; t++) begin
         if (bus.busy) bcnt++;
         if (bus.done) seen = 1'b1;
         else begin
            k++;
            @(negedge clk);
         end
      end
      check({name, "_done_seen"}, seen, 1'b1);
      check({name, "_latency"}, k, g);
      check({name, "_busy_cycles"}, bcnt, g);
      check({name, "_data"}, bus.data_out, exp);
      @(negedge clk);
      check({name, "_done_width"}, bus.done, 1'b0);
      check({name, "_hold"}, bus.data_out, exp);
   endtask

   initial begin
      logic [NC-1:0] e;
      int            dcnt;
      logic [NC-1:0] dval;

      bus.start = 1'b0;
      bus.data_in = '0;
      bus.rule = '0;
      bus.generations = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_data", bus.data_out, 8'h00);
      cmp_en = 1'b1;
      rst = 1'b0;

      run_directed(8'b0001_0000, RULE_90, 8'd1, 8'b0010_1000, "r90_g1");
      run_directed(8'hA5, RULE_IDENT, 8'd5, 8'hA5, "ident_g5");
      run_directed(8'h3C, 8'(($urandom)), 8'd0, 8'h3C, "gen0");
`ifdef REVAL_WRAP_EN
      run_directed(8'b1000_0000, RULE_SHIFT_L, 8'd1, 8'h01, "shl_g1");
      run_directed(8'b1000_0000, RULE_SHIFT_L, 8'd3, 8'h04, "shl_g3");
`else
      run_directed(8'b1000_0000, RULE_SHIFT_L, 8'd1, 8'h00, "shl_g1");
      run_directed(8'b1000_0000, RULE_SHIFT_L, 8'd3, 8'h00, "shl_g3");
`endif
      run_directed(8'hFF, RULE_CLEAR, 8'd2, 8'h00, "clear_g2");
      e = 8'h6D;
      for (int i = 0; i < 255; i++) e = ref_step(e, 8'd30);
      run_directed(8'h6D, 8'd30, 8'hFF, e, "max_run");

      // Start pulses during a run must be ignored.
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.data_in = 8'h96;
      bus.rule = RULE_90;
      bus.generations = 8'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.data_in = 8'hFF;
      bus.rule = RULE_CLEAR;
      bus.generations = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
      dcnt = 0;
      dval = '0;
      for (int t = 0; t < 20; t++) begin
         if (bus.done) begin
            dcnt++;
            dval = bus.data_out;
         end
         @(negedge clk);
      end
      e = 8'h96;
      for (int i = 0; i < 10; i++) e = ref_step(e, RULE_90);
      check("ignore_start_dones", dcnt, 1);
      check("ignore_start_data", dval, e);

      // Reset in the middle of a run aborts it without a done pulse.
      bus.start = 1'b1;
      bus.data_in = 8'h5B;
      bus.rule = RULE_90;
      bus.generations = 8'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      check("abort_data", bus.data_out, 8'h00);
      dcnt = 0;
      for (int t = 0; t < 12; t++) begin
         if (bus.done) dcnt++;
         @(negedge clk);
      end
      check("abort_no_done", dcnt, 0);
      run_directed(8'b0001_0000, RULE_90, 8'd1, 8'b0010_1000, "after_abort");

      // Random traffic: the model checks every cycle, including ignored starts and resets.
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.data_in = 8'($urandom);
         bus.rule = 8'($urandom);
         bus.generations = 8'($urandom_range(0, 12));
      end
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
